piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
- Parallel-in/serial-out framer that sits directly upstream of the 4-stage serial shift register (siso) and drives its serial input every clock.
- Accepts one WIDTH-bit word per valid/ready handshake and emits it one bit per cycle on `so`, optionally followed by an even-parity bit.
- Supports zero-gap back-to-back frames so the downstream shift register sees a continuous bit stream.

Parameters:
- WIDTH, 8, data word width in bits; must be at least 2.
- MSB_FIRST, 1, 1 sends din[WIDTH-1] first; 0 sends din[0] first.
- PARITY_EN, 0, 1 appends one even-parity bit (XOR of all data bits) after the data bits.
- IDLE_LEVEL, 0, value driven on `so` when no frame is active.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- din  input  WIDTH  parallel word; sampled only on an accept edge.
- din_valid  input  1  upstream has a word on din.
- din_ready  output  1  block can accept a word this cycle (combinational from state).
- so  output  1  serial bit out (registered); connects to siso `si`.
- so_valid  output  1  `so` carries a frame bit this cycle (registered).
- frame_start  output  1  one-cycle pulse coincident with the first bit of a frame on `so`.
- frame_done  output  1  one-cycle pulse coincident with the last bit (data or parity) of a frame on `so`.
- busy  output  1  equals so_valid.

Behaviour:
- Frame length L = WIDTH + PARITY_EN bits.
- Reset (asynchronous, any time, including mid-frame):
  - so = IDLE_LEVEL; so_valid = frame_start = frame_done = busy = 0.
  - Bit counter = 0; shift register = 0; FSM = IDLE.
  - A partially sent frame is discarded and is not resumed.
- FSM states:
  - IDLE: no frame on `so`.
  - DATA: data bits being presented.
  - PAR: parity bit being presented; only reachable when PARITY_EN = 1.
- din_ready = 1 in IDLE, and also while the final bit of the current frame is on `so` (frame_done = 1); 0 otherwise.
- Accept = din_valid & din_ready at a rising edge. On accept:
  - `so` takes the first bit; so_valid = 1, frame_start = 1.
  - The remaining bits are loaded into the shift register.
  - The counter is set to 1; the parity accumulator is set to XOR(din); FSM goes to DATA.
- Latency: a word accepted at edge k has bit i (0..L-1) on `so` during the cycle following edge k+i.
- DATA: each edge presents the next bit, frame_start = 0 and the counter increments.
  - When the counter reaches WIDTH-1, the last data bit is presented.
  - PARITY_EN = 0: frame_done = 1 alongside that last data bit.
  - PARITY_EN = 1: next edge presents the parity bit, state = PAR, frame_done = 1.
- End of frame (the edge following the frame_done cycle):
  - If accept occurs: start the new frame immediately, with no idle cycle.
  - Otherwise: so = IDLE_LEVEL, so_valid = 0, FSM = IDLE.
- din and din_valid are ignored whenever din_ready = 0; changes to din mid-frame must not corrupt the output.
- WIDTH = 2 with PARITY_EN = 0: frame_done is asserted on the second bit; back-to-back throughput is still 1 bit per cycle.
- No X-propagation: `so` is always 0/1 after reset.

Test Plan:
- Reset then idle, din_valid = 0 for 10 cycles -> so = 0, so_valid = 0, din_ready = 1 throughout.
- WIDTH=8, MSB_FIRST=1, PARITY_EN=0, accept din = 0xB4 -> so = 1,0,1,1,0,1,0,0 on the 8 cycles after accept; frame_start on bit 0; frame_done on bit 7; din_ready = 0 on bits 0-6; then so_valid drops to 0.
- MSB_FIRST=0, din = 0xB4 -> so = 0,0,1,0,1,1,0,1; same pulse timing.
- PARITY_EN=1, MSB_FIRST=1, din = 0x07 -> so = 0,0,0,0,0,1,1,1,1 (parity = 1); frame_done only on the 9th bit. Repeat with 0xB4 -> 9th bit = 0.
- Back-to-back: din_valid held high with 0xB4 then 0x5A -> 16 consecutive so_valid cycles, so = 10110100 01011010, no gap. Changing din during frame 1 while din_ready = 0 has no effect.
- Reset asserted at bit 3 of 0xFF -> so = 0 and so_valid = 0 immediately (asynchronous). After release, a new accept of 0x81 gives 1,0,0,0,0,0,0,1. Integration check: `so` driving siso appears on siso `so` 4 cycles later, bit-exact.

Source files
------------

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//
// Parallel-in / serial-out framer. Accepts one WIDTH-bit word per valid/ready
// handshake and presents it one bit per clock on `so`. When PARITY_EN is set,
// an even-parity bit (XOR of all data bits) follows the data bits. A new word
// may be accepted while the last bit of the current frame is on `so`, so
// consecutive frames are emitted with no idle cycle between them.
//
// Parameters:
//   WIDTH      data word width in bits (>= 2)
//   MSB_FIRST  1: din[WIDTH-1] leaves first, 0: din[0] leaves first
//   PARITY_EN  1: append an even-parity bit after the data bits
//   IDLE_LEVEL level driven on `so` while no frame is active
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   din          parallel word, sampled only on an accept edge
//   din_valid    upstream has a word on din
//   din_ready    a word can be accepted this cycle (combinational from state)
//   so           registered serial output
//   so_valid     `so` carries a frame bit this cycle
//   frame_start  pulse with the first bit of a frame
//   frame_done   pulse with the last bit (data or parity) of a frame
//   busy         same as so_valid
// -----------------------------------------------------------------------------
module piso_serializer #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             so,
  output logic             so_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy
);

  // Counter must hold WIDTH itself: with parity enabled it reaches WIDTH
  // once every data bit has been presented.
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ALL_DATA  = CW'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_PAR  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             par_q, par_d;
  logic             so_q, so_d;
  logic             so_valid_q, so_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             frame_done_q, frame_done_d;

  logic             accept;
  logic             end_frame;
  logic             first_bit;
  logic [WIDTH-1:0] load_rest;
  logic             next_bit;
  logic [WIDTH-1:0] shifted;

  // The shift register always keeps the next bit to send at the end that
  // leaves first, so loading and shifting only differ in direction.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign first_bit = din[WIDTH-1];
      assign load_rest = din << 1;
      assign next_bit  = shreg_q[WIDTH-1];
      assign shifted   = shreg_q << 1;
    end else begin : g_lsb_first
      assign first_bit = din[0];
      assign load_rest = din >> 1;
      assign next_bit  = shreg_q[0];
      assign shifted   = shreg_q >> 1;
    end
  endgenerate

  // Ready while idle, and while the final bit of a frame is on `so` so the
  // next frame can follow without a gap.
  assign din_ready = (state_q == S_IDLE) || frame_done_q;
  assign accept    = din_valid && din_ready;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shreg_d       = shreg_q;
    par_d         = par_q;
    so_d          = so_q;
    so_valid_d    = so_valid_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    end_frame     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // nothing on so; a start is handled by the accept override below
      end
      S_DATA: begin
        if (frame_done_q) begin
          // last data bit already shown (no parity): frame is over
          end_frame = 1'b1;
        end else if (PARITY_EN && (cnt_q == ALL_DATA)) begin
          so_d         = par_q;
          state_d      = S_PAR;
          frame_done_d = 1'b1;
        end else begin
          so_d         = next_bit;
          shreg_d      = shifted;
          cnt_d        = cnt_q + CW'(1);
          frame_done_d = !PARITY_EN && (cnt_q == LAST_DATA);
        end
      end
      S_PAR: begin
        end_frame = 1'b1;
      end
      default: begin
        end_frame = 1'b1;
      end
    endcase

    if (end_frame) begin
      so_d       = IDLE_LEVEL;
      so_valid_d = 1'b0;
      state_d    = S_IDLE;
      cnt_d      = '0;
    end

    // Accept only happens in IDLE or at end of frame, so it cleanly
    // overrides whatever the case statement decided.
    if (accept) begin
      so_d          = first_bit;
      so_valid_d    = 1'b1;
      frame_start_d = 1'b1;
      frame_done_d  = 1'b0;
      shreg_d       = load_rest;
      cnt_d         = CW'(1);
      par_d         = ^din;
      state_d       = S_DATA;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      shreg_q       <= '0;
      par_q         <= 1'b0;
      so_q          <= IDLE_LEVEL;
      so_valid_q    <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shreg_q       <= shreg_d;
      par_q         <= par_d;
      so_q          <= so_d;
      so_valid_q    <= so_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign so          = so_q;
  assign so_valid    = so_valid_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign busy        = so_valid_q;

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
//
// Four serializer configurations share one din/din_valid stimulus:
//   0: WIDTH=8 MSB first, no parity      1: WIDTH=8 LSB first, idle level 1
//   2: WIDTH=8 MSB first, parity         3: WIDTH=2 MSB first, no parity
// Each is checked every cycle against a frame-list reference model, plus a
// directed vector table and hand-written multi-cycle sequences.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

  localparam int N = 4;

  function automatic int cfg_w(input int i);
    return (i == 3) ? 2 : 8;
  endfunction
  function automatic bit cfg_msb(input int i);
    return (i != 1);
  endfunction
  function automatic bit cfg_par(input int i);
    return (i == 2);
  endfunction
  function automatic bit cfg_idle(input int i);
    return (i == 1);
  endfunction

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   din;
  logic         din_valid;
  logic [N-1:0] rdy_w, so_w, sv_w, fs_w, fd_w, busy_w;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_dut
      localparam int WI = cfg_w(gi);
      piso_serializer #(
        .WIDTH      (WI),
        .MSB_FIRST  (cfg_msb(gi)),
        .PARITY_EN  (cfg_par(gi)),
        .IDLE_LEVEL (cfg_idle(gi))
      ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din[WI-1:0]),
        .din_valid   (din_valid),
        .din_ready   (rdy_w[gi]),
        .so          (so_w[gi]),
        .so_valid    (sv_w[gi]),
        .frame_start (fs_w[gi]),
        .frame_done  (fd_w[gi]),
        .busy        (busy_w[gi])
      );
    end
  endgenerate

  // Downstream 4-stage shift register fed by configuration 0.
  logic [3:0] siso_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) siso_q <= '0;
    else     siso_q <= {siso_q[2:0], so_w[0]};
  end

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the frame currently on `so` as a list of bits.
  logic        m_act [N];
  int          m_pos [N];
  int          m_len [N];
  logic [15:0] m_bits[N];

  function automatic logic m_ready(input int i);
    return !m_act[i] || (m_pos[i] == m_len[i] - 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_act[i]  = 1'b0;
      m_pos[i]  = 0;
      m_len[i]  = 0;
      m_bits[i] = '0;
    end
  endtask

  task automatic check_all(input string nm);
    logic [5:0] got, exp;
    logic       e_so;
    for (int i = 0; i < N; i++) begin
      e_so = m_act[i] ? m_bits[i][m_pos[i]] : cfg_idle(i);
      exp  = {e_so, m_act[i], m_act[i] && (m_pos[i] == 0),
              m_act[i] && (m_pos[i] == m_len[i] - 1), m_ready(i), m_act[i]};
      got  = {so_w[i], sv_w[i], fs_w[i], fd_w[i], rdy_w[i], busy_w[i]};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL %s dut%0d t=%0t so/sv/fs/fd/rdy/busy got %b expected %b",
                 nm, i, $time, got, exp);
      end
    end
  endtask

  // One clock: model decides accepts from pre-edge state, then DUTs are checked.
  task automatic step(input string nm);
    logic       acc[N];
    logic [7:0] d;
    int         w;
    logic       p;
    d = din;
    for (int i = 0; i < N; i++) acc[i] = din_valid && m_ready(i);
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        w = cfg_w(i);
        if (acc[i]) begin
          p = 1'b0;
          m_bits[i] = '0;
          for (int k = 0; k < w; k++) begin
            p = p ^ d[k];
            m_bits[i][k] = cfg_msb(i) ? d[w-1-k] : d[k];
          end
          if (cfg_par(i)) m_bits[i][w] = p;
          m_len[i] = w + (cfg_par(i) ? 1 : 0);
          m_pos[i] = 0;
          m_act[i] = 1'b1;
        end else if (m_act[i]) begin
          if (m_pos[i] == m_len[i] - 1) m_act[i] = 1'b0;
          else m_pos[i]++;
        end
      end
    end
    #1;
    check_all(nm);
  endtask

  task automatic drain();
    din_valid = 1'b0;
    for (int c = 0; c < 12; c++) step("drain");
  endtask

  // Asynchronous reset in the middle of a clock phase; outputs must clear
  // before any further clock edge.
  task automatic async_reset_pulse();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Send one word (or two back to back, w1 following w0 after fl bits) and
  // collect nb bits of `so` from configuration idx.
  task automatic collect(input int idx, input logic [7:0] w0, input logic [7:0] w1,
                         input int fl, input bit two, input int nb,
                         input logic [15:0] exp_bits, input string nm);
    logic [15:0] got;
    logic        all_v;
    got   = '0;
    all_v = 1'b1;
    for (int c = 0; c < nb; c++) begin
      din_valid = (c == 0) || (two && c <= fl);
      din       = (c == 0) ? w0 : w1;
      step(nm);
      got[nb-1-c] = so_w[idx];
      all_v       = all_v & sv_w[idx];
    end
    din_valid = 1'b0;
    n_cmp++;
    if (got !== exp_bits) begin
      n_err++;
      $display("FAIL %s bits got %h expected %h", nm, got, exp_bits);
    end
    n_cmp++;
    if (all_v !== 1'b1) begin
      n_err++;
      $display("FAIL %s so_valid gap got %b expected 1", nm, all_v);
    end
    drain();
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [4:0] e;   // {so, so_valid, frame_start, frame_done, din_ready}
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [4:0] got5;
    logic [7:0] s_bits, t_bits;
    logic       s_arr[12];
    logic       t_arr[12];

    tbl[0] = '{1'b1, 8'hB4, 5'b11100};
    tbl[1] = '{1'b1, 8'hFF, 5'b01000};
    tbl[2] = '{1'b1, 8'hFF, 5'b11000};
    tbl[3] = '{1'b1, 8'hFF, 5'b11000};
    tbl[4] = '{1'b1, 8'hFF, 5'b01000};
    tbl[5] = '{1'b1, 8'hFF, 5'b11000};
    tbl[6] = '{1'b1, 8'hFF, 5'b01000};
    tbl[7] = '{1'b1, 8'hFF, 5'b01011};
    tbl[8] = '{1'b0, 8'h00, 5'b00001};
    tbl[9] = '{1'b0, 8'h00, 5'b00001};

    rst       = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int c = 0; c < 10; c++) step("idle");

    // Directed 0xB4 frame on configuration 0; din changes while not ready.
    for (int r = 0; r < 10; r++) begin
      din_valid = tbl[r].v;
      din       = tbl[r].d;
      step("table");
      got5 = {so_w[0], sv_w[0], fs_w[0], fd_w[0], rdy_w[0]};
      n_cmp++;
      if (got5 !== tbl[r].e) begin
        n_err++;
        $display("FAIL table row %0d got %b expected %b", r, got5, tbl[r].e);
      end
    end
    drain();

    collect(1, 8'hB4, 8'h00, 8, 1'b0, 8,  16'h002D, "lsb_b4");
    collect(2, 8'h07, 8'h00, 9, 1'b0, 9,  16'h000F, "par_07");
    collect(2, 8'hB4, 8'h00, 9, 1'b0, 9,  16'h0168, "par_b4");
    collect(0, 8'hB4, 8'h5A, 8, 1'b1, 16, 16'hB45A, "b2b_b4_5a");
    collect(3, 8'h02, 8'h01, 2, 1'b1, 4,  16'h0009, "w2_b2b");

    // Reset with bit 3 of 0xFF on so.
    din       = 8'hFF;
    din_valid = 1'b1;
    step("rst_frame");
    din_valid = 1'b0;
    for (int c = 0; c < 3; c++) step("rst_frame");
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({so_w[0], sv_w[0]} !== 2'b00) begin
      n_err++;
      $display("FAIL midframe_rst so/sv got %b expected 00", {so_w[0], sv_w[0]});
    end
    model_reset();
    check_all("midframe_rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) step("post_rst");

    // 0x81 after reset, also through the downstream 4-stage shift register.
    din       = 8'h81;
    din_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step("siso");
      din_valid = 1'b0;
      s_arr[c]  = so_w[0];
      t_arr[c]  = siso_q[3];
    end
    for (int c = 0; c < 8; c++) begin
      s_bits[7-c] = s_arr[c];
      t_bits[7-c] = t_arr[c+4];
    end
    n_cmp++;
    if (s_bits !== 8'h81) begin
      n_err++;
      $display("FAIL after_rst_81 got %h expected 81", s_bits);
    end
    n_cmp++;
    if (t_bits !== 8'h81) begin
      n_err++;
      $display("FAIL siso_81 got %h expected 81", t_bits);
    end
    drain();

    // Randomized traffic with one asynchronous reset in the middle.
    for (int c = 0; c < 400; c++) begin
      din       = 8'($urandom);
      din_valid = ($urandom_range(0, 3) != 0);
      step("random");
      if (c == 200) async_reset_pulse();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
